// File: rtl/ising_run_ctrl.sv
// Run sequencer for the coupled-oscillator Ising array: holds the array in reset,
// lets it anneal, then resolves each oscillator's phase against oscillator 0.
module ising_osc_lane #(
    parameter int SYNC_STAGES = 2,
    parameter int SAMPLE_LOG2 = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic osc,
    input  logic s_ref,
    input  logic clr,
    input  logic en,
    output logic s,
    output logic spin
);
    localparam int MW = SAMPLE_LOG2 + 1;
    localparam logic [MW-1:0] HALF = MW'(2 ** (SAMPLE_LOG2 - 1));

    logic [SYNC_STAGES-1:0] sync;
    logic [MW-1:0]          match;
    logic [MW-1:0]          match_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '0;
        else        sync <= {sync[SYNC_STAGES-2:0], osc};
    end

    assign s        = sync[SYNC_STAGES-1];
    assign match_nx = match + MW'(s == s_ref);
    // Decision uses the count including the final window cycle; a tie resolves to 0.
    assign spin     = match_nx < HALF;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   match <= '0;
        else if (clr) match <= '0;
        else if (en)  match <= match_nx;
    end
endmodule

module ising_run_ctrl #(
    parameter int NUM_SPINS   = 8,
    parameter int CNT_W       = 32,
    parameter int SAMPLE_LOG2 = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 axi_rstn,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_W-1:0]     reset_cycles,
    input  logic [CNT_W-1:0]     run_cycles,
    input  logic [NUM_SPINS-1:0] osc_in,
    output logic                 ising_rstn,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_SPINS-1:0] spin_out
);
    typedef enum logic [2:0] {S_IDLE, S_RESET, S_RUN, S_SAMPLE, S_DONE} state_t;

    localparam logic [CNT_W-1:0] W_LAST = CNT_W'((2 ** SAMPLE_LOG2) - 1);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     r_last;
    logic [CNT_W-1:0]     t_last;
    logic [NUM_SPINS-1:0] s_vec;
    logic [NUM_SPINS-1:0] lane_spin;
    logic                 start_acc;
    logic                 lane_clr;
    logic                 lane_en;

    assign start_acc = start && !abort && (state == S_IDLE || state == S_DONE);
    assign lane_clr  = start_acc || abort;
    assign lane_en   = (state == S_SAMPLE) && !abort;

    // Lane 0 compares against itself, so its match count is always W and its spin is 0.
    for (genvar i = 0; i < NUM_SPINS; i++) begin : g_lane
        ising_osc_lane #(
            .SYNC_STAGES(SYNC_STAGES),
            .SAMPLE_LOG2(SAMPLE_LOG2)
        ) u_lane (
            .clk  (clk),
            .rst_n(axi_rstn),
            .osc  (osc_in[i]),
            .s_ref(s_vec[0]),
            .clr  (lane_clr),
            .en   (lane_en),
            .s    (s_vec[i]),
            .spin (lane_spin[i])
        );
    end

    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            state      <= S_IDLE;
            cnt        <= '0;
            r_last     <= '0;
            t_last     <= '0;
            ising_rstn <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            spin_out   <= '0;
        end else if (abort) begin
            state      <= S_IDLE;
            cnt        <= '0;
            ising_rstn <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_acc) begin
                        // Store last-cycle indices; zero lengths collapse to one cycle.
                        r_last     <= (reset_cycles == '0) ? '0 : reset_cycles - 1'b1;
                        t_last     <= (run_cycles == '0) ? '0 : run_cycles - 1'b1;
                        cnt        <= '0;
                        state      <= S_RESET;
                        ising_rstn <= 1'b0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                S_RESET: begin
                    if (cnt == r_last) begin
                        cnt        <= '0;
                        state      <= S_RUN;
                        ising_rstn <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (cnt == t_last) begin
                        cnt   <= '0;
                        state <= S_SAMPLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    if (cnt == W_LAST) begin
                        cnt      <= '0;
                        state    <= S_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        spin_out <= lane_spin;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    ising_rstn <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ising_run_ctrl.sv
// Directed bench for ising_run_ctrl: run timing, spin resolution, abort, restart, async reset.
module tb_ising_run_ctrl;
    localparam int N  = 8;
    localparam int CW = 32;
    localparam int SL = 6;
    localparam int SS = 2;
    localparam int W  = 64;

    logic          clk = 1'b0;
    logic          axi_rstn = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] reset_cycles = '0;
    logic [CW-1:0] run_cycles = '0;
    logic [N-1:0]  osc_in = '0;
    logic          ising_rstn;
    logic          busy;
    logic          done;
    logic [N-1:0]  spin_out;

    int   n_chk = 0;
    int   n_err = 0;
    int   ecount = 0;
    int   osc_mode = 0;
    logic hist [0:8191];

    ising_run_ctrl #(.NUM_SPINS(N), .CNT_W(CW), .SAMPLE_LOG2(SL), .SYNC_STAGES(SS)) dut (
        .clk         (clk),
        .axi_rstn    (axi_rstn),
        .start       (start),
        .abort       (abort),
        .reset_cycles(reset_cycles),
        .run_cycles  (run_cycles),
        .osc_in      (osc_in),
        .ising_rstn  (ising_rstn),
        .busy        (busy),
        .done        (done),
        .spin_out    (spin_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // 0: all low; 1: square wave period 10 (bit1 in phase, bit2 inverted, bit3 low);
    // 2: tie pattern on bit3, bit2 held high; 3: only bit1 high.
    function automatic logic [N-1:0] osc_pat(input int e, input int mode);
        logic [N-1:0] o;
        logic         w;
        o = '0;
        w = ((e / 5) % 2) == 1;
        case (mode)
            1: begin o = {N{w}}; o[2] = ~w; o[3] = 1'b0; end
            2: begin o[2] = 1'b1; o[3] = e[0]; end
            3: o[1] = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (ecount < 8191) ecount++;
        hist[ecount] = osc_in[0];
        #1;
        osc_in = osc_pat(ecount, osc_mode);
    endtask

    task automatic do_run(input int r, input int t, input int p1, input int p2,
                          output int rise_c, output int done_c, output int kedge,
                          output logic [N-1:0] spin_before);
        int   cyc;
        logic prev_busy;
        reset_cycles = r;
        run_cycles   = t;
        start = 1'b1;
        tick();
        start = 1'b0;
        kedge = ecount;
        cyc = 1;
        rise_c = 0;
        prev_busy = busy;
        spin_before = spin_out;
        chk("busy_after_start", busy, 1);
        chk("rstn_after_start", ising_rstn, 0);
        while (!done && cyc < 400) begin
            prev_busy = busy;
            spin_before = spin_out;
            if (cyc == p1 || cyc == p2) start = 1'b1;
            tick();
            start = 1'b0;
            cyc++;
            if (ising_rstn && rise_c == 0) rise_c = cyc;
        end
        if (!done) chk("run_timeout", 0, 1);
        done_c = cyc;
        chk("busy_falls_with_done", {30'd0, prev_busy, busy}, 32'd2);
    endtask

    initial begin
        int rise_c, done_c, kedge, cnt, e;
        logic [N-1:0] sb;
        logic [N-1:0] exp_spin;

        tick(); tick();
        chk("rst_rstn", ising_rstn, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_spin", spin_out, 0);
        axi_rstn = 1'b1;
        tick();

        // Basic timing R=3, T=5
        osc_mode = 0;
        do_run(3, 5, -1, -1, rise_c, done_c, kedge, sb);
        chk("t1_rise", rise_c, 4);
        chk("t1_done", done_c, 73);
        chk("t1_spin", spin_out, 0);

        // Back-to-back from DONE, zero lengths
        do_run(0, 0, -1, -1, rise_c, done_c, kedge, sb);
        chk("t2_rise", rise_c, 2);
        chk("t2_done", done_c, 67);

        // Spin resolution on a square wave
        osc_mode = 1;
        tick(); tick(); tick();
        do_run(2, 4, -1, -1, rise_c, done_c, kedge, sb);
        chk("t3_done", done_c, 71);
        cnt = 0;
        for (int j = 1; j <= W; j++) begin
            e = kedge + 2 + 4 + j - SS;
            if (hist[e] == 1'b0) cnt++;
        end
        exp_spin = 8'b0000_0100;
        exp_spin[3] = (cnt < W / 2);
        chk("t3_spin", spin_out, exp_spin);

        // Tie on bit3 resolves to 0
        osc_mode = 2;
        tick(); tick(); tick();
        do_run(2, 4, -1, -1, rise_c, done_c, kedge, sb);
        chk("t4_tie_spin", spin_out, 8'b0000_0100);

        // Start pulses in RESET and SAMPLE ignored; spin changes only at new done
        osc_mode = 3;
        tick(); tick(); tick();
        do_run(3, 5, 2, 40, rise_c, done_c, kedge, sb);
        chk("t5_rise", rise_c, 4);
        chk("t5_done", done_c, 73);
        chk("t5_spin_before", sb, 8'b0000_0100);
        chk("t5_spin_new", spin_out, 8'b0000_0010);

        // Abort at cycle 20 of RUN
        osc_mode = 0;
        reset_cycles = 2;
        run_cycles = 40;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 22; c++) tick();
        chk("t6_in_run_rstn", ising_rstn, 1);
        chk("t6_in_run_busy", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t6_abort_rstn", ising_rstn, 0);
        chk("t6_abort_busy", busy, 0);
        chk("t6_abort_done", done, 0);
        chk("t6_abort_spin", spin_out, 8'b0000_0010);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("t6_abort_start_busy", busy, 0);
        tick(); tick();
        chk("t6_stay_idle_busy", busy, 0);
        chk("t6_stay_idle_rstn", ising_rstn, 0);

        // Asynchronous reset mid-SAMPLE
        osc_mode = 1;
        reset_cycles = 2;
        run_cycles = 4;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 30; c++) tick();
        chk("t7_pre_busy", busy, 1);
        chk("t7_pre_rstn", ising_rstn, 1);
        #2;
        axi_rstn = 1'b0;
        #1;
        chk("t7_async_rstn", ising_rstn, 0);
        chk("t7_async_busy", busy, 0);
        chk("t7_async_done", done, 0);
        chk("t7_async_spin", spin_out, 0);
        tick(); tick();
        axi_rstn = 1'b1;
        osc_mode = 0;
        tick();
        do_run(1, 1, -1, -1, rise_c, done_c, kedge, sb);
        chk("t7_rerun_rise", rise_c, 2);
        chk("t7_rerun_done", done_c, 67);
        chk("t7_rerun_spin", spin_out, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
